amba_apb_mem_slave: RTL and testbench

AMBA_APB_MEM_SLAVE -- requirements
Module: amba_apb_mem_slave

---
 rtl/amba_apb_mem_slave.sv | 98 +++++++++
 tb/tb_amba_apb_mem_slave.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/amba_apb_mem_slave.sv
// APB3 memory slave: word storage, programmable wait states, pslverr on bad address.
// Optional byte-lane write strobes are enabled by defining AMBA_APB_PSTRB_EN.
module amba_apb_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int IW = $clog2(DEPTH);
    localparam int NB = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]            state, state_nxt, cur_state;
    logic [3:0]            cnt, cnt_nxt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_word;
    logic [IW-1:0]         idx;
    logic                  addr_err, complete, do_write;

    assign idx      = paddr[IW+1:2];
    assign addr_err = (paddr[1:0] != 2'b00) || ((paddr >> 2) >= ADDR_WIDTH'(DEPTH));
    assign complete = (state == ACCESS) && (cnt == 4'(WAIT_STATES));
    assign do_write = complete && psel && penable && pwrite && !addr_err;

    assign pready  = complete && !preset;
    assign pslverr = pready && addr_err;
    assign prdata  = (pready && !pwrite && !addr_err) ? mem[idx] : '0;

    // The setup phase is recognised in the cycle the master drives it, so
    // ACCESS is entered on the first penable edge and WAIT_STATES=0 takes 2 cycles.
    always_comb begin
        cur_state = state;
        if (state == IDLE && psel && !penable)
            cur_state = SETUP;
        state_nxt = IDLE;
        cnt_nxt   = cnt;
        case (cur_state)
            SETUP: begin
                state_nxt = ACCESS;
                cnt_nxt   = '0;
            end
            ACCESS: begin
                if (complete)
                    state_nxt = (psel && !penable) ? SETUP : IDLE;
                else if (!psel)
                    state_nxt = IDLE;
                else begin
                    state_nxt = ACCESS;
                    cnt_nxt   = cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef AMBA_APB_PSTRB_EN
    logic [DATA_WIDTH-1:0] bmask;
    for (genvar g = 0; g < NB; g++) begin : g_lane
        assign bmask[g*8 +: 8] = {8{pstrb[g]}};
    end
    assign wr_word = (mem[idx] & ~bmask) | (pwdata & bmask);
`else
    logic unused_pstrb;
    assign unused_pstrb = ^pstrb;
    assign wr_word      = pwdata;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
            cnt   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[IW'(i)] <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (do_write)
                mem[idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_amba_apb_mem_slave.sv
// Self-checking bench: two slaves (0 and 3 wait states) against a word-array model.
module tb_amba_apb_mem_slave;

`ifdef AMBA_APB_PSTRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        preset;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic [31:0] model [2][64];
    int          ws    [2] = '{0, 3};
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    amba_apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .pclk(clk), .preset(preset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );

    amba_apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(64), .WAIT_STATES(3)) u_dut3 (
        .pclk(clk), .preset(preset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (!STRB_EN || strb[b])
                r = (r & ~(32'hFF << (8 * b))) | (nw & (32'hFF << (8 * b)));
        return r;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= 64);
    endfunction

    // Entered and left just after a rising edge; the slave's bus returns to idle
    // at exit unless the next call drives a new setup in the same time step.
    task automatic apb(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input string tag);
        int          cyc;
        bit          done;
        bit          err;
        logic [31:0] rd;
        logic        se;
        err = addr_bad(addr);
        rd  = '0;
        se  = 1'b0;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
        @(negedge clk);
        check($sformatf("%s/d%0d setup pready", tag, d), pready[d], 0);
        @(posedge clk); #1;
        penable[d] = 1'b1;
        cyc  = 1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (pready[d]) begin
                done = 1'b1;
                rd   = prdata[d];
                se   = pslverr[d];
            end else begin
                @(posedge clk); #1;
            end
        end
        check($sformatf("%s/d%0d completed", tag, d), done, 1);
        check($sformatf("%s/d%0d cycles", tag, d), cyc, 2 + ws[d]);
        check($sformatf("%s/d%0d pslverr", tag, d), se, err);
        if (wr) begin
            check($sformatf("%s/d%0d prdata on write", tag, d), rd, 0);
            if (!err)
                model[d][addr / 4] = merge(model[d][addr / 4], wdata, strb);
        end else begin
            check($sformatf("%s/d%0d prdata", tag, d), rd, err ? 32'h0 : model[d][addr / 4]);
        end
        last_rd = rd;
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          d;
        bit          wr;
        logic [31:0] a;
        int          r;

        preset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0;
            for (int j = 0; j < 64; j++) model[i][j] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset/d%0d pready", i), pready[i], 0);
            check($sformatf("reset/d%0d pslverr", i), pslverr[i], 0);
            check($sformatf("reset/d%0d prdata", i), prdata[i], 0);
        end
        @(posedge clk); #1;
        preset = 1'b0;
        @(negedge clk);
        check("post-reset pready d0", pready[0], 0);
        check("post-reset pready d3", pready[1], 0);
        @(posedge clk); #1;

        for (int i = 0; i < 2; i++) begin
            apb(i, 1, 32'h60, 32'hAA, 4'hF, "wr60");
            apb(i, 0, 32'h60, 0, 4'hF, "rd60");
            check($sformatf("rd60 value d%0d", i), last_rd, 32'hAA);

            apb(i, 1, 32'h100, 32'hDEADBEEF, 4'hF, "wr oob");
            apb(i, 0, 32'h62, 0, 4'hF, "rd misaligned");
            apb(i, 0, 32'h0, 0, 4'hF, "rd word0 after oob");
            apb(i, 0, 32'hFC, 0, 4'hF, "rd last word");

            apb(i, 1, 32'h60, 32'h11223344, 4'hF, "strb init");
            apb(i, 1, 32'h60, 32'hAABBCCDD, 4'b0101, "strb write");
            apb(i, 0, 32'h60, 0, 4'hF, "strb read");
            check($sformatf("strb value d%0d", i), last_rd, STRB_EN ? 32'h11BB33DD : 32'hAABBCCDD);

            apb(i, 1, 32'h04, 32'h0404_0404, 4'hF, "b2b first");
            apb(i, 1, 32'h08, 32'h0808_0808, 4'hF, "b2b second");
            apb(i, 0, 32'h04, 0, 4'hF, "b2b rd4");
            apb(i, 0, 32'h08, 0, 4'hF, "b2b rd8");
        end

        // abort a write on the wait-state slave by dropping psel mid-wait
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h60; pwdata[1] = 32'h5555_5555; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("abort wait pready", pready[1], 0);
            @(posedge clk); #1;
        end
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        apb(1, 0, 32'h60, 0, 4'hF, "rd after abort");

        // reset in what would be the completing cycle of a write
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h60; pwdata[1] = 32'h7777_7777; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        preset = 1'b1;
        @(negedge clk);
        check("reset mid pready", pready[1], 0);
        check("reset mid pslverr", pslverr[1], 0);
        check("reset mid prdata", prdata[1], 0);
        @(posedge clk); #1;
        preset = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j++) model[i][j] = '0;
        @(negedge clk);
        check("after mid reset pready", pready[1], 0);
        @(posedge clk); #1;
        apb(1, 0, 32'h60, 0, 4'hF, "rd60 after reset");
        check("rd60 after reset value", last_rd, 0);
        apb(0, 0, 32'h04, 0, 4'hF, "d0 cleared");

        for (int n = 0; n < 60; n++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      a = ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
            else if (r == 1) a = ($urandom_range(64, 1000) * 4);
            else             a = $urandom_range(0, 63) * 4;
            apb(d, wr, a, $urandom, 4'($urandom_range(0, 15)), "rand");
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 64; j += 9)
                apb(i, 0, 32'(j * 4), 0, 4'hF, "sweep");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
